// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered, handshaked RISC-V immediate generator.
// It sits between decode and the ID/EX register. The block decodes the
// I/S/B/U/J formats from opcode[6:0] and sign-extends the immediate to XLEN.
// It also reports the instruction format and whether the opcode is illegal.
// A main output register and a one-entry skid register give full throughput.
// in_ready comes straight from a flop, so it has no combinational path from
// out_ready.
// Optional feature: define IMM_ERR_CNT_EN to add the saturating err_cnt
// output, which counts illegal instructions as they are handed downstream.
module imm_gen_pipe #(
    parameter int XLEN = 32'sd64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
`ifdef IMM_ERR_CNT_EN
    ,
    output logic [15:0]     err_cnt
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    // decoded view of the incoming instruction
    logic [31:0]     dec_imm32_s;
    logic [XLEN-1:0] dec_imm_s;
    logic [2:0]      dec_fmt_s;
    logic            dec_ill_s;

    // main (output) register and skid register
    logic            main_valid_r, main_valid_s;
    logic [XLEN-1:0] main_imm_r,   main_imm_s;
    logic [2:0]      main_fmt_r,   main_fmt_s;
    logic            main_ill_r,   main_ill_s;
    logic            skid_valid_r, skid_valid_s;
    logic [XLEN-1:0] skid_imm_r,   skid_imm_s;
    logic [2:0]      skid_fmt_r,   skid_fmt_s;
    logic            skid_ill_r,   skid_ill_s;
    logic            in_ready_r;

    logic            in_fire_s;
    logic            out_fire_s;

    assign in_fire_s  = in_valid && in_ready_r;
    assign out_fire_s = main_valid_r && out_ready;

    // Decode the opcode into a 32-bit sign-extended immediate, a format code
    // and an illegal flag. Illegal opcodes give a zero immediate.
    always_comb begin
        dec_imm32_s = 32'd0;
        dec_fmt_s   = FMT_NONE;
        dec_ill_s   = 1'b1;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                dec_imm32_s = {{20{instr[31]}}, instr[31:20]};
                dec_fmt_s   = FMT_I;
                dec_ill_s   = 1'b0;
            end
            OP_IMM32: begin
                // the *W op-imm forms exist only on RV64
                if (XLEN == 32'sd64) begin
                    dec_imm32_s = {{20{instr[31]}}, instr[31:20]};
                    dec_fmt_s   = FMT_I;
                    dec_ill_s   = 1'b0;
                end else begin
                    dec_imm32_s = 32'd0;
                    dec_fmt_s   = FMT_NONE;
                    dec_ill_s   = 1'b1;
                end
            end
            OP_STORE: begin
                dec_imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec_fmt_s   = FMT_S;
                dec_ill_s   = 1'b0;
            end
            OP_BRANCH: begin
                dec_imm32_s = {{19{instr[31]}}, instr[31], instr[7],
                               instr[30:25], instr[11:8], 1'b0};
                dec_fmt_s   = FMT_B;
                dec_ill_s   = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                dec_imm32_s = {instr[31:12], 12'd0};
                dec_fmt_s   = FMT_U;
                dec_ill_s   = 1'b0;
            end
            OP_JAL: begin
                dec_imm32_s = {{11{instr[31]}}, instr[31], instr[19:12],
                               instr[20], instr[30:21], 1'b0};
                dec_fmt_s   = FMT_J;
                dec_ill_s   = 1'b0;
            end
            default: begin
                dec_imm32_s = 32'd0;
                dec_fmt_s   = FMT_NONE;
                dec_ill_s   = 1'b1;
            end
        endcase
    end

    // Bit 31 of the 32-bit immediate is always instr[31], so a signed resize
    // extends the immediate correctly to XLEN.
    assign dec_imm_s = XLEN'($signed(dec_imm32_s));

    // Compute the next state of the main and skid registers from the handshake.
    // The main register refills when it is empty or is being drained. Skid data
    // takes priority over the input, which keeps the instructions in order.
    always_comb begin
        main_valid_s = main_valid_r;
        main_imm_s   = main_imm_r;
        main_fmt_s   = main_fmt_r;
        main_ill_s   = main_ill_r;
        skid_valid_s = skid_valid_r;
        skid_imm_s   = skid_imm_r;
        skid_fmt_s   = skid_fmt_r;
        skid_ill_s   = skid_ill_r;
        if (!main_valid_r || out_fire_s) begin
            if (skid_valid_r) begin
                main_valid_s = 1'b1;
                main_imm_s   = skid_imm_r;
                main_fmt_s   = skid_fmt_r;
                main_ill_s   = skid_ill_r;
                skid_valid_s = 1'b0;
            end else if (in_fire_s) begin
                main_valid_s = 1'b1;
                main_imm_s   = dec_imm_s;
                main_fmt_s   = dec_fmt_s;
                main_ill_s   = dec_ill_s;
            end else begin
                main_valid_s = 1'b0;
            end
        end else begin
            // output stalled: the main register holds, and a new accept is parked
            if (in_fire_s) begin
                skid_valid_s = 1'b1;
                skid_imm_s   = dec_imm_s;
                skid_fmt_s   = dec_fmt_s;
                skid_ill_s   = dec_ill_s;
            end else begin
                skid_valid_s = skid_valid_r;
            end
        end
    end

    // Update the pipeline registers. in_ready is registered from the next skid state.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_r <= 1'b0;
            main_imm_r   <= '0;
            main_fmt_r   <= FMT_NONE;
            main_ill_r   <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_imm_r   <= '0;
            skid_fmt_r   <= FMT_NONE;
            skid_ill_r   <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            main_valid_r <= main_valid_s;
            main_imm_r   <= main_imm_s;
            main_fmt_r   <= main_fmt_s;
            main_ill_r   <= main_ill_s;
            skid_valid_r <= skid_valid_s;
            skid_imm_r   <= skid_imm_s;
            skid_fmt_r   <= skid_fmt_s;
            skid_ill_r   <= skid_ill_s;
            in_ready_r   <= !skid_valid_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign imm       = main_imm_r;
    assign fmt       = main_fmt_r;
    assign illegal   = main_ill_r;

`ifdef IMM_ERR_CNT_EN
    logic [15:0] err_cnt_r;

    // Count illegal instructions as they are handed downstream, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_r <= 16'd0;
        end else if (out_fire_s && main_ill_r && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

endmodule
